instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
Streaming encoder for RISC-V I-type and S-type instructions. It accepts decoded fields plus a 32-bit sign-extended immediate and range-checks the immediate against the 12-bit signed field. It packs the fields into a 32-bit instruction word and emits that word with a word-aligned instruction-memory write address. It sits in the boot/debug loader path and feeds instruction memory. Its immediate placement is the exact inverse of the core's immediate extraction: ImmSrc=0 selects I-type, ImmSrc=1 selects S-type.

Parameters:
ADDR_BASE, 32'h0000_0000, first write address after reset or clear
ERR_CNT_W, 8, width of the saturating range-error counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
clear  input  1  synchronous flush of pipeline and address counter
in_valid  input  1  request valid
in_ready  output  1  encoder can accept request
opcode  input  7  instruction opcode [6:0]
funct3  input  3  funct3 field
rd  input  5  destination register (I-type only)
rs1  input  5  source register 1
rs2  input  5  source register 2 (S-type only)
imm  input  32  sign-extended immediate value
ImmSrc  input  1  0 = I-type, 1 = S-type
out_valid  output  1  encoded word valid
out_ready  input  1  downstream accepts word
out_instr  output  32  encoded instruction
out_addr  output  32  write address for out_instr
range_err  output  1  one-cycle pulse: request dropped, imm out of range
err_count  output  ERR_CNT_W  saturating count of dropped requests

Behaviour:
- Reset (rst_n=0 at clk edge):
  - s1_valid=0, s2_valid=0, out_valid=0, range_err=0, err_count=0.
  - out_instr=0, out_addr=ADDR_BASE.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-transfer discards all in-flight requests; no partial output is produced.
- Pipeline structure: two register stages.
  - S1 captures the fields and computes in_range = (imm[31:11] all 0s or all 1s).
  - S2 holds the packed word.
- Handshakes:
  - Input transfer occurs on in_valid & in_ready.
  - Output transfer occurs on out_valid & out_ready.
  - s2_adv = s1_valid & (!s2_valid | out_ready).
  - in_ready = !s1_valid | s2_adv. This is combinational and allows full throughput of 1 word/cycle.
- Latency: a request accepted at edge N appears on out_valid after edge N+1, assuming no stall.
- Out-of-range immediate:
  - When S1 advances with in_range=0, S2 is not loaded. If S2 is also draining that cycle, S2 becomes empty.
  - range_err pulses high for exactly one cycle.
  - err_count increments and saturates at all 1s.
- Packing rules:
  - I-type: {imm[11:0], rs1, funct3, rd, opcode}.
  - S-type: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - Fields not used by the selected type are ignored.
- Stall and data stability:
  - out_instr and out_valid are held stable while out_valid & !out_ready.
  - The input fields are sampled only on the accepting edge.
- Address counter:
  - out_addr changes only after an output transfer, by +4.
  - It wraps modulo 2^32 (32'hFFFF_FFFC + 4 gives 0).
  - out_addr always refers to the word currently on out_instr.
- clear:
  - Empties S1 and S2, resets out_addr to ADDR_BASE, and forces range_err=0.
  - err_count is kept.
  - A handshake in the same cycle as clear is discarded.
  - rst_n has priority over clear.

Optional Feature:
ENC_ROUNDTRIP_CHECK_EN
- Defined:
  - Adds output port rt_mismatch (1 bit).
  - S2 re-extracts the immediate from out_instr using the core's extraction: I-type {20{b31}, b31:20}; S-type {20{b31}, b31:25, b11:7}.
  - The extracted value is compared with the registered imm.
  - rt_mismatch is registered, pulses one cycle on mismatch of a valid word, and resets to 0.
- Undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- I-type: opcode=7'h13, funct3=0, rd=1, rs1=0, imm=32'hFFFF_FFFF, ImmSrc=0, out_ready=1 -> after 2 edges, out_instr=32'hFFF0_0093, out_addr=ADDR_BASE, range_err=0.
- S-type: opcode=7'h23, funct3=2, rs1=3, rs2=2, imm=8, ImmSrc=1 -> out_instr=32'h0021_A423. The next word uses out_addr=ADDR_BASE+4.
- Range error: imm=32'h0000_0800, ImmSrc=0 -> no out_valid, range_err pulses 1 cycle, err_count=1. A following valid request still emits at the same out_addr.
- Backpressure: stream 4 valid requests with out_ready=0 for 5 cycles -> in_ready drops after 2 accepts and out_instr stays stable. On releasing out_ready, all 4 words emerge in order with addresses +0, +4, +8, +12, and none are lost.
- Wrap and clear: ADDR_BASE=32'hFFFF_FFFC, two transfers -> addresses FFFF_FFFC then 0000_0000. Asserting clear mid-stall -> out_valid=0 next cycle, out_addr=ADDR_BASE, err_count unchanged.
- Reset mid-operation: drop rst_n with both stages full -> next cycle out_valid=0, in_ready=1, err_count=0. With ENC_ROUNDTRIP_CHECK_EN, rt_mismatch stays 0 across all cases above.

Source files
------------

// File: rtl/instr_encoder.sv
// ============================================================================
//  Module      : instr_encoder
//  Description : Two-stage streaming encoder packing RISC-V I/S-type fields
//                into instruction words with word-aligned write addresses.
//                Optional macro ENC_ROUNDTRIP_CHECK_EN adds rt_mismatch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [31:0]          imm,
    input  logic                 ImmSrc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic [31:0]          out_addr,
    output logic                 range_err,
`ifdef ENC_ROUNDTRIP_CHECK_EN
    output logic                 rt_mismatch,
`endif
    output logic [ERR_CNT_W-1:0] err_count
);

`ifdef ENC_ROUNDTRIP_CHECK_EN
    localparam int c_IMM_W = 32;
`else
    localparam int c_IMM_W = 12;
`endif

    logic                 r_s1_valid;
    logic                 r_s1_in_range;
    logic [6:0]           r_s1_opcode;
    logic [2:0]           r_s1_funct3;
    logic [4:0]           r_s1_rd;
    logic [4:0]           r_s1_rs1;
    logic [4:0]           r_s1_rs2;
    logic [c_IMM_W-1:0]   r_s1_imm;
    logic                 r_s1_immsrc;

    logic                 r_s2_valid;
    logic [31:0]          r_s2_instr;
    logic [31:0]          r_addr;
    logic                 r_range_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_s2_adv;
    logic                 w_s2_load;
    logic                 w_s1_drop;
    logic                 w_in_range;
    logic [31:0]          w_packed;

    assign w_s2_adv   = r_s1_valid & (~r_s2_valid | out_ready);
    assign in_ready   = ~r_s1_valid | w_s2_adv;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_s2_valid & out_ready;
    assign w_s2_load  = w_s2_adv & r_s1_in_range;
    assign w_s1_drop  = w_s2_adv & ~r_s1_in_range;

    // Fits the 12-bit signed field when bits [31:11] are a pure sign extension
    assign w_in_range = (&imm[31:11]) | ~(|imm[31:11]);

    always_comb begin
        w_packed = '0;
        if (r_s1_immsrc) begin
            w_packed = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                        r_s1_imm[4:0], r_s1_opcode};
        end else begin
            w_packed = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd,
                        r_s1_opcode};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (clear) begin
            r_s1_valid <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_in_range <= 1'b1;
            r_s1_opcode   <= '0;
            r_s1_funct3   <= '0;
            r_s1_rd       <= '0;
            r_s1_rs1      <= '0;
            r_s1_rs2      <= '0;
            r_s1_imm      <= '0;
            r_s1_immsrc   <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_in_range <= w_in_range;
            r_s1_opcode   <= opcode;
            r_s1_funct3   <= funct3;
            r_s1_rd       <= rd;
            r_s1_rs1      <= rs1;
            r_s1_rs2      <= rs2;
            r_s1_imm      <= imm[c_IMM_W-1:0];
            r_s1_immsrc   <= ImmSrc;
        end
    end

    // A dropped request leaves S2 empty if its previous word drains this cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_instr <= '0;
        end else if (clear) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_s2_instr <= w_packed;
        end else if (w_out_fire) begin
            r_s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr <= ADDR_BASE;
        end else if (clear) begin
            r_addr <= ADDR_BASE;
        end else if (w_out_fire) begin
            r_addr <= r_addr + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_range_err <= 1'b0;
            r_err_count <= '0;
        end else if (clear) begin
            r_range_err <= 1'b0;
        end else begin
            r_range_err <= w_s1_drop;
            if (w_s1_drop && (r_err_count != {ERR_CNT_W{1'b1}})) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
        end
    end

`ifdef ENC_ROUNDTRIP_CHECK_EN
    logic [31:0] w_rt_ext;
    logic        r_rt_mismatch;

    // Same extraction the core applies to the word about to enter S2
    always_comb begin
        w_rt_ext = '0;
        if (r_s1_immsrc) begin
            w_rt_ext = {{20{w_packed[31]}}, w_packed[31:25], w_packed[11:7]};
        end else begin
            w_rt_ext = {{20{w_packed[31]}}, w_packed[31:20]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rt_mismatch <= 1'b0;
        end else if (clear) begin
            r_rt_mismatch <= 1'b0;
        end else begin
            r_rt_mismatch <= w_s2_load & (w_rt_ext != r_s1_imm);
        end
    end

    assign rt_mismatch = r_rt_mismatch;
`endif

    assign out_valid = r_s2_valid;
    assign out_instr = r_s2_instr;
    assign out_addr  = r_addr;
    assign range_err = r_range_err;
    assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Self-checking bench for instr_encoder (default build).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n, clear;
    logic        in_valid, in_ready, out_valid, out_ready, range_err;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, out_instr, out_addr;
    logic        ImmSrc;
    logic [7:0]  err_count;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, range_err2;
    logic [31:0] out_instr2, out_addr2;
    logic [7:0]  err_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_BASE(32'h0000_0000), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .ImmSrc(ImmSrc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .range_err(range_err), .err_count(err_count)
    );

    instr_encoder #(.ADDR_BASE(32'hFFFF_FFFC), .ERR_CNT_W(8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .opcode(opcode), .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
        .imm(imm), .ImmSrc(ImmSrc),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_instr(out_instr2), .out_addr(out_addr2),
        .range_err(range_err2), .err_count(err_count2)
    );

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        immsrc;
        logic        exp_err;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input vec_t v);
        opcode = v.opcode; funct3 = v.funct3; rd = v.rd;
        rs1 = v.rs1; rs2 = v.rs2; imm = v.imm; ImmSrc = v.immsrc;
    endtask

    // Stream word k: addi x(k+1), x0, 16*k
    task automatic set_bp(input int k);
        opcode = 7'h13; funct3 = 3'd0; rd = 5'(k + 1); rs1 = 5'd0; rs2 = 5'd0;
        imm = 32'(k * 16); ImmSrc = 1'b0;
    endtask

    function automatic logic [31:0] bp_instr(input int k);
        logic [31:0] v_imm;
        logic [4:0]  v_rd;
        v_imm = 32'(k * 16);
        v_rd  = 5'(k + 1);
        return {v_imm[11:0], 5'd0, 3'd0, v_rd, 7'h13};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_addr;
        logic [7:0]  exp_errs;
        int          idx, got;
        logic        acc;

        vecs[0] = '{7'h13, 3'd0, 5'd1,  5'd0,  5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFF0_0093};
        vecs[1] = '{7'h23, 3'd2, 5'd31, 5'd3,  5'd2,  32'h0000_0008, 1'b1, 1'b0, 32'h0021_A423};
        vecs[2] = '{7'h13, 3'd0, 5'd1,  5'd0,  5'd0,  32'h0000_0800, 1'b0, 1'b1, 32'h0};
        vecs[3] = '{7'h03, 3'd2, 5'd5,  5'd2,  5'd0,  32'h0000_07FF, 1'b0, 1'b0, 32'h7FF1_2283};
        vecs[4] = '{7'h13, 3'd0, 5'd31, 5'd31, 5'd0,  32'hFFFF_F800, 1'b0, 1'b0, 32'h800F_8F93};
        vecs[5] = '{7'h23, 3'd3, 5'd0,  5'd8,  5'd9,  32'hFFFF_FFFC, 1'b1, 1'b0, 32'hFE94_3E23};
        vecs[6] = '{7'h23, 3'd2, 5'd0,  5'd1,  5'd1,  32'hFFFF_F7FF, 1'b1, 1'b1, 32'h0};
        vecs[7] = '{7'h13, 3'd0, 5'd1,  5'd0,  5'd0,  32'h0000_0000, 1'b0, 1'b0, 32'h0000_0093};

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
        out_ready = 1'b1; out_ready2 = 1'b1;
        set_vec(vecs[0]);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_addr", out_addr, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_range_err", {31'd0, range_err}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);

        exp_addr = 32'h0;
        exp_errs = 8'd0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            set_vec(vecs[i]);
            in_valid = 1'b1;
            @(negedge clk);
            chk("vec_in_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            if (vecs[i].exp_err) begin
                exp_errs++;
                chk("vec_err_no_valid", {31'd0, out_valid}, 32'd0);
                chk("vec_err_pulse", {31'd0, range_err}, 32'd1);
                chk("vec_err_count", {24'd0, err_count}, {24'd0, exp_errs});
            end else begin
                chk("vec_out_valid", {31'd0, out_valid}, 32'd1);
                chk("vec_out_instr", out_instr, vecs[i].exp_instr);
                chk("vec_out_addr", out_addr, exp_addr);
                chk("vec_no_err", {31'd0, range_err}, 32'd0);
                exp_addr += 32'd4;
            end
            @(posedge clk); #1;
            chk("vec_err_cleared", {31'd0, range_err}, 32'd0);
            chk("vec_drained", {31'd0, out_valid}, 32'd0);
        end

        // Backpressure: four requests against a stalled output
        out_ready = 1'b0;
        idx = 0;
        set_bp(0);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            acc = in_valid & in_ready;
            if (c >= 2) chk("bp_stable_instr", out_instr, bp_instr(0));
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                set_bp(idx);
            end
        end
        chk("bp_accepts", 32'(idx), 32'd2);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 4; c++) begin
            @(negedge clk);
            acc = in_valid & in_ready;
            if (out_valid) begin
                chk("bp_word", out_instr, bp_instr(got));
                chk("bp_addr", out_addr, exp_addr);
                exp_addr += 32'd4;
                got++;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) set_bp(idx);
                else in_valid = 1'b0;
            end
        end
        chk("bp_all_words", 32'(got), 32'd4);
        in_valid = 1'b0;

        // Address wrap on the second instance
        set_vec(vecs[0]);
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        got = 0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            @(negedge clk);
            if (out_valid2) begin
                chk("wrap_addr", out_addr2, (got == 0) ? 32'hFFFF_FFFC : 32'h0000_0000);
                got++;
            end
            @(posedge clk); #1;
        end
        chk("wrap_words", 32'(got), 32'd2);

        // Clear during a stall, with a handshake in the clear cycle
        out_ready = 1'b0;
        set_vec(vecs[1]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("clr_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("clr_pre_addr", out_addr, exp_addr);
        set_vec(vecs[3]);
        in_valid = 1'b1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_out_addr", out_addr, 32'h0);
        chk("clr_wrap_addr", out_addr2, 32'hFFFF_FFFC);
        chk("clr_err_kept", {24'd0, err_count}, {24'd0, exp_errs});
        chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("clr_discarded", {31'd0, out_valid}, 32'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        set_vec(vecs[0]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_vec(vecs[1]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_full_valid", {31'd0, out_valid}, 32'd1);
        chk("mid_full_stall", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_err_count", {24'd0, err_count}, 32'd0);
        chk("mid_rst_addr", out_addr, 32'h0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst_no_output", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
